run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy, start, endd, stop, err  in  1 each  run-control flags from the upstream counter stage.
REQ-004 status, status_valid  in  1 each  serial status bit and its qualifier from the upstream stage.
REQ-005 interrupt  in  1  upstream abort request.
REQ-006 irq_ack  in  1  host acknowledge of irq.
REQ-007 irq  out  1  report pending; held until acknowledged.
REQ-008 cause  out  2  termination cause: 00 abort, 01 endd, 10 stop, 11 err.
REQ-009 status_word  out  8  collected status bits; newest bit in LSB.
REQ-010 status_cnt  out  4  count of status bits captured in the current run; saturates at 8.
REQ-011 err_cycles  out  8  count of err-high cycles in the current run; saturates at 255.
REQ-012 run_count  out  8  completed (acknowledged) runs; wraps 255->0.
REQ-013 busy  out  1  high in RUN and REPORT states.

Function
REQ-014 FSM states SHALL be IDLE, RUN and REPORT; busy = (state != IDLE).
REQ-015 IDLE->RUN SHALL occur on any cycle with start=1; on that edge status_word, status_cnt, err_cycles and cause SHALL clear to 0.
REQ-016 In RUN, each cycle with status_valid=1 SHALL shift status into the status_word LSB (word <= {word[6:0],status}) and increment status_cnt up to 8.
REQ-017 status_valid outside RUN SHALL be ignored.
REQ-018 In RUN, each cycle with err=1 SHALL increment err_cycles, saturating at 255.
REQ-019 Termination SHALL occur in RUN when rdy=1 and any of err/stop/endd is 1; the cause priority is err(11) > stop(10) > endd(01).
REQ-020 A termination flag with rdy=0 SHALL NOT terminate; err_cycles still counts it.
REQ-021 Abort: interrupt=1 in RUN with no valid termination that cycle SHALL set cause=00; a valid termination in the same cycle takes precedence.
REQ-022 On termination or abort, the state SHALL go RUN->REPORT and irq SHALL be 1 from the next cycle (1-cycle latency).
REQ-023 A status_valid or err present in the terminating cycle SHALL still be captured/counted in that cycle.
REQ-024 In REPORT: irq=1; status_word, status_cnt, err_cycles and cause SHALL be frozen; start, status_valid, err and interrupt SHALL be ignored.
REQ-025 REPORT with irq_ack=1 SHALL go to IDLE, clear irq next cycle and increment run_count (mod 256).
REQ-026 irq_ack outside REPORT SHALL have no effect.
REQ-027 A start in the first IDLE cycle after acknowledge SHALL begin a new run normally.
REQ-028 A start while in RUN SHALL be ignored (no restart, no clear).

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, irq=0, cause=00, status_word=0, status_cnt=0, err_cycles=0, run_count=0, busy=0; this overrides all other inputs, including mid-run and mid-REPORT.
REQ-030 In the first cycle after rst deasserts the block SHALL be in IDLE and accept start.

Verification
REQ-031 Run: start; status_valid with bits 1,0,1,1; then rdy=1,endd=1 -> next cycle irq=1, cause=01, status_word=0x0B, status_cnt=4, err_cycles=0; irq_ack -> IDLE, run_count=1.
REQ-032 Run with err=1 for 3 cycles while rdy=0, then rdy=1,err=1,stop=1 -> cause=11, err_cycles=4.
REQ-033 Run with 10 status_valid pulses of 1 -> status_cnt=8, status_word=0xFF; interrupt=1 -> cause=00, irq=1.
REQ-034 Hold REPORT without ack for 20 cycles while toggling start/status_valid/err -> all outputs unchanged, irq=1 throughout.
REQ-035 256 start/endd/ack runs -> run_count wraps to 0; rst asserted mid-RUN -> all outputs 0 and busy=0 next cycle.

Source files
------------

// File: rtl/run_monitor.sv
// Run-control monitor: tracks one run from start to termination or abort,
// collects serial status bits and err cycles, then holds a report until acked.
module run_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       start,
  input  logic       endd,
  input  logic       stop,
  input  logic       err,
  input  logic       status,
  input  logic       status_valid,
  input  logic       interrupt,
  input  logic       irq_ack,
  output logic       irq,
  output logic [1:0] cause,
  output logic [7:0] status_word,
  output logic [3:0] status_cnt,
  output logic [7:0] err_cycles,
  output logic [7:0] run_count,
  output logic       busy,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_ABORT = 2'b00;
  localparam logic [1:0] CAUSE_ENDD  = 2'b01;
  localparam logic [1:0] CAUSE_STOP  = 2'b10;
  localparam logic [1:0] CAUSE_ERR   = 2'b11;

  state_t     state;
  logic       term;
  logic [1:0] term_cause;

  assign fsm_state = state;

  // A termination flag only counts when the upstream stage marks it ready.
  always_comb begin
    term       = rdy && (err || stop || endd);
    term_cause = CAUSE_ENDD;
    if (err)       term_cause = CAUSE_ERR;
    else if (stop) term_cause = CAUSE_STOP;
  end

  // Report handshake: irq is the valid; it stays high with cause and the
  // collected fields frozen until irq_ack is sampled high in REPORT, and that
  // same edge retires the report. irq_ack at any other time is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq         <= 1'b0;
      cause       <= CAUSE_ABORT;
      status_word <= 8'd0;
      status_cnt  <= 4'd0;
      err_cycles  <= 8'd0;
      run_count   <= 8'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            cause       <= CAUSE_ABORT;
            status_word <= 8'd0;
            status_cnt  <= 4'd0;
            err_cycles  <= 8'd0;
          end
        end
        RUN: begin
          // Capture happens even on the cycle that ends the run.
          if (status_valid) begin
            status_word <= {status_word[6:0], status};
            if (status_cnt != 4'd8) status_cnt <= status_cnt + 4'd1;
          end
          if (err && (err_cycles != 8'hFF)) err_cycles <= err_cycles + 8'd1;
          if (term) begin
            cause <= term_cause;
            state <= REPORT;
            irq   <= 1'b1;
          end else if (interrupt) begin
            cause <= CAUSE_ABORT;
            state <= REPORT;
            irq   <= 1'b1;
          end
        end
        REPORT: begin
          if (irq_ack) begin
            state     <= IDLE;
            irq       <= 1'b0;
            busy      <= 1'b0;
            run_count <= run_count + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: expected reports are queued at the stimulus
// side and a monitor compares them whenever irq rises.
module tb_run_monitor;

  bit         clk;
  logic       rst, rdy, start, endd, stop, err, status, status_valid, interrupt, irq_ack;
  logic       irq, busy;
  logic [1:0] cause, fsm_state;
  logic [7:0] status_word, err_cycles, run_count;
  logic [3:0] status_cnt;
  logic [21:0] snap;

  int checks = 0;
  int errors = 0;
  int rc = 0;
  logic irq_q = 1'b0;
  logic [21:0] exp_q[$];

  run_monitor dut (
    .clk(clk), .rst(rst), .rdy(rdy), .start(start), .endd(endd), .stop(stop),
    .err(err), .status(status), .status_valid(status_valid),
    .interrupt(interrupt), .irq_ack(irq_ack), .irq(irq), .cause(cause),
    .status_word(status_word), .status_cnt(status_cnt), .err_cycles(err_cycles),
    .run_count(run_count), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  assign snap = {cause, status_word, status_cnt, err_cycles};

  function automatic logic [21:0] rpt(logic [1:0] c, logic [7:0] w, logic [3:0] n, logic [7:0] e);
    return {c, w, n, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; rdy = 0; start = 0; endd = 0; stop = 0; err = 0;
    status = 0; status_valid = 0; interrupt = 0; irq_ack = 0;
  endtask

  // One clock: inputs set before the call are applied at the next posedge,
  // outputs are then sampled at the following negedge.
  task automatic tick();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic ack_run();
    irq_ack = 1; tick();
    rc = (rc + 1) % 256;
    check("ack_irq", {31'd0, irq}, 32'd0);
    check("ack_run_count", {24'd0, run_count}, rc);
  endtask

  // Scoreboard monitor: a rising irq presents a report.
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL report_unexpected: got 0x%0h expected none", snap);
      end else begin
        check("report", {10'd0, snap}, {10'd0, exp_q.pop_front()});
      end
    end
    irq_q = irq;
  end

  initial begin
    clear_inputs();
    rst = 1; start = 1; tick();
    check("reset_snap", {10'd0, snap}, 32'd0);
    check("reset_flags", {28'd0, irq, busy, fsm_state}, 32'd0);
    check("reset_run_count", {24'd0, run_count}, 32'd0);

    // Basic run: bits 1,0,1,1 then rdy+endd.
    start = 1; tick();
    check("busy_run", {30'd0, busy, fsm_state == 2'd1}, 32'd3);
    status_valid = 1; status = 1; tick();
    status_valid = 1; status = 0; tick();
    status_valid = 1; status = 1; tick();
    status_valid = 1; status = 1; tick();
    exp_q.push_back(rpt(2'b01, 8'h0B, 4'd4, 8'd0));
    rdy = 1; endd = 1; tick();
    check("irq_latency", {31'd0, irq}, 32'd1);
    ack_run();

    // IDLE ignores status_valid and irq_ack.
    status_valid = 1; status = 1; irq_ack = 1; tick();
    check("idle_ignore_status", {10'd0, snap}, {10'd0, rpt(2'b01, 8'h0B, 4'd4, 8'd0)});
    check("idle_ignore_ack", {24'd0, run_count}, rc);

    // err without rdy counts but does not terminate; start in RUN ignored.
    start = 1; tick();
    err = 1; tick();
    err = 1; start = 1; tick();
    err = 1; tick();
    check("err_no_rdy", {23'd0, irq, err_cycles}, 32'd3);
    exp_q.push_back(rpt(2'b11, 8'h00, 4'd0, 8'd4));
    rdy = 1; err = 1; stop = 1; tick();
    ack_run();

    // Status saturation then abort, followed by a frozen REPORT.
    start = 1; tick();
    for (int i = 0; i < 10; i++) begin
      status_valid = 1; status = 1; tick();
    end
    check("cnt_saturate", {20'd0, status_cnt, status_word}, {20'd0, 4'd8, 8'hFF});
    exp_q.push_back(rpt(2'b00, 8'hFF, 4'd8, 8'd0));
    interrupt = 1; tick();
    for (int i = 0; i < 20; i++) begin
      start = i[0]; status_valid = 1; status = i[1]; err = ~i[0]; interrupt = 1; rdy = 1; endd = 1;
      tick();
      if (i % 5 == 4) begin
        check("report_hold", {9'd0, irq, snap}, {9'd0, 1'b1, rpt(2'b00, 8'hFF, 4'd8, 8'd0)});
      end
    end
    ack_run();

    // Start on the first IDLE cycle after ack; capture in terminating cycle.
    start = 1; tick();
    check("restart_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(rpt(2'b11, 8'h01, 4'd1, 8'd1));
    rdy = 1; err = 1; status_valid = 1; status = 1; tick();
    ack_run();

    // Valid termination beats a same-cycle interrupt.
    start = 1; tick();
    exp_q.push_back(rpt(2'b01, 8'h00, 4'd0, 8'd0));
    rdy = 1; endd = 1; interrupt = 1; tick();
    ack_run();

    // stop outranks endd.
    start = 1; tick();
    exp_q.push_back(rpt(2'b10, 8'h00, 4'd0, 8'd0));
    rdy = 1; stop = 1; endd = 1; tick();
    ack_run();

    // err_cycles saturates at 255.
    start = 1; tick();
    for (int i = 0; i < 260; i++) begin
      err = 1; tick();
    end
    exp_q.push_back(rpt(2'b01, 8'h00, 4'd0, 8'hFF));
    rdy = 1; endd = 1; err = 0; tick();
    ack_run();

    // run_count wrap from a fresh reset.
    rst = 1; tick();
    rc = 0;
    check("rst_run_count", {24'd0, run_count}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      start = 1; tick();
      exp_q.push_back(rpt(2'b01, 8'h00, 4'd0, 8'd0));
      rdy = 1; endd = 1; tick();
      irq_ack = 1; tick();
      rc = (rc + 1) % 256;
      if (i == 254) check("run_count_255", {24'd0, run_count}, 32'd255);
    end
    check("run_count_wrap", {24'd0, run_count}, 32'd0);

    // Reset mid-RUN after a partial run.
    start = 1; tick();
    start = 1; tick();
    status_valid = 1; status = 1; err = 1; tick();
    rst = 1; start = 1; tick();
    check("rst_mid_run", {6'd0, irq, busy, fsm_state, snap}, 32'd0);

    // First cycle after reset accepts start.
    start = 1; tick();
    check("post_rst_start", {30'd0, fsm_state}, 32'd1);
    exp_q.push_back(rpt(2'b01, 8'h00, 4'd0, 8'd0));
    rdy = 1; endd = 1; tick();
    rc = 0;
    ack_run();

    // Reset mid-REPORT.
    start = 1; tick();
    exp_q.push_back(rpt(2'b00, 8'h00, 4'd0, 8'd0));
    interrupt = 1; tick();
    rst = 1; irq_ack = 1; tick();
    check("rst_mid_report", {21'd0, irq, busy, fsm_state, run_count}, 32'd0);

    tick();
    tick();
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reports: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
